// File: rtl/if_id_inst_queue_pkg.sv
// Shared definitions for the IF->ID instruction queue: field widths,
// exception codes and the IfToNextBus packing shared by IF and ID.
// Optional feature macro: IBUF_BYPASS_EN (0-cycle bypass of an empty queue).
package if_id_inst_queue_pkg;

  localparam int IQ_DEPTH  = 8;
  localparam int IQ_PC_W   = 32;
  localparam int IQ_INST_W = 32;
  localparam int IQ_EXC_W  = 7;   // {excp_valid, ecode[5:0]}

  // Fetch-side exception codes
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  // IfToNextBus packing, LSB first: excp, inst, pc
  localparam int IBUS_EXC_LSB  = 0;
  localparam int IBUS_INST_LSB = IBUS_EXC_LSB + IQ_EXC_W;
  localparam int IBUS_PC_LSB   = IBUS_INST_LSB + IQ_INST_W;
  localparam int IBUS_W        = IBUS_PC_LSB + IQ_PC_W;

  typedef struct packed {
    logic [IQ_PC_W-1:0]   pc;
    logic [IQ_INST_W-1:0] inst;
    logic [IQ_EXC_W-1:0]  excp;
  } if_to_next_bus_t;

endpackage

// File: rtl/if_id_inst_queue_if.sv
// IF/ID handshake bundle for the instruction queue. The queue takes the
// slave view; the IF/ID/flush drivers take the master view.
interface if_id_inst_queue_if
  import if_id_inst_queue_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH,
  parameter int PC_W   = IQ_PC_W,
  parameter int INST_W = IQ_INST_W,
  parameter int EXC_W  = IQ_EXC_W
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              if_valid_i;
  logic [PC_W-1:0]   if_pc_i;
  logic [INST_W-1:0] if_inst_i;
  logic [EXC_W-1:0]  if_excp_i;
  logic              now_allowin_o;
  logic              id_allowin_i;
  logic              id_valid_o;
  logic [PC_W-1:0]   id_pc_o;
  logic [INST_W-1:0] id_inst_o;
  logic [EXC_W-1:0]  id_excp_o;
  logic              excep_flush_i;
  logic              other_flush_i;
  logic [CW-1:0]     count_o;

  modport slave (
    input  if_valid_i, if_pc_i, if_inst_i, if_excp_i, id_allowin_i,
           excep_flush_i, other_flush_i,
    output now_allowin_o, id_valid_o, id_pc_o, id_inst_o, id_excp_o, count_o
  );

  modport master (
    output if_valid_i, if_pc_i, if_inst_i, if_excp_i, id_allowin_i,
           excep_flush_i, other_flush_i,
    input  now_allowin_o, id_valid_o, id_pc_o, id_inst_o, id_excp_o, count_o
  );

endinterface

// File: rtl/if_id_iq_mem.sv
// Queue storage: DEPTH x W entries, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module if_id_iq_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 71,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [DEPTH-1:0][W-1:0] r_mem;

  // Write the incoming entry at the tail slot
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_id_inst_queue.sv
// IF->ID decoupling instruction queue. Holds pointers, occupancy,
// handshake and flush; storage lives in if_id_iq_mem.
// Optional feature macro: IBUF_BYPASS_EN - an empty queue forwards the IF
// entry straight to ID in the same cycle when ID can take it.
module if_id_inst_queue
  import if_id_inst_queue_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH,
  parameter int PC_W   = IQ_PC_W,
  parameter int INST_W = IQ_INST_W,
  parameter int EXC_W  = IQ_EXC_W
) (
  input  logic          clk,
  input  logic          rst,
  if_id_inst_queue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = PC_W + INST_W + EXC_W;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [AW:0]   r_count;

  logic          w_flush, w_push, w_pop, w_empty, w_allowin, w_bypass;
  logic [EW-1:0] w_wr_data, w_rd_data, w_head;

  assign w_flush   = bus.excep_flush_i | bus.other_flush_i;
  assign w_empty   = (r_count == '0);
  // Full is judged on registered state only; a pop this cycle does not
  // free a slot for IF until the next cycle.
  assign w_allowin = (r_count != CNT_FULL);

  // Same field order as if_to_next_bus_t: pc high, excp low
  assign w_wr_data = {bus.if_pc_i, bus.if_inst_i, bus.if_excp_i};

`ifdef IBUF_BYPASS_EN
  assign w_bypass       = w_empty & bus.if_valid_i & bus.id_allowin_i & ~w_flush;
  assign bus.id_valid_o = ~w_empty | (bus.if_valid_i & ~w_flush);
  assign w_head         = w_empty ? w_wr_data : w_rd_data;
`else
  assign w_bypass       = 1'b0;
  assign bus.id_valid_o = ~w_empty;
  assign w_head         = w_rd_data;
`endif

  // A bypassed entry is consumed directly by ID, so it is neither written
  // nor popped; pop only ever retires a stored entry.
  assign w_push = bus.if_valid_i & w_allowin & ~w_flush & ~w_bypass;
  assign w_pop  = ~w_empty & bus.id_allowin_i & ~w_flush;

  assign bus.now_allowin_o = w_allowin;
  assign bus.count_o       = r_count;
  assign {bus.id_pc_o, bus.id_inst_o, bus.id_excp_o} = w_head;

  // Pointer and occupancy update; reset, then flush, take priority
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  if_id_iq_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

endmodule

// File: tb/tb_if_id_inst_queue.sv
// Directed self-checking bench for if_id_inst_queue (DEPTH=8).
module tb_if_id_inst_queue;
  import if_id_inst_queue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  if_id_inst_queue_if #(.DEPTH(8)) bus ();

  if_id_inst_queue #(.DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs changed afterwards apply to the next edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [6:0] ex);
    bus.if_valid_i = v;
    bus.if_pc_i    = pc;
    bus.if_inst_i  = pc ^ 32'h0000_1357;
    bus.if_excp_i  = ex;
  endtask

  initial begin
    bus.if_valid_i    = 1'b0;
    bus.if_pc_i       = '0;
    bus.if_inst_i     = '0;
    bus.if_excp_i     = '0;
    bus.id_allowin_i  = 1'b0;
    bus.excep_flush_i = 1'b0;
    bus.other_flush_i = 1'b0;

    // 1 reset
    tick(); tick();
    chk("rst_valid",   64'(bus.id_valid_o), 64'd0);
    chk("rst_allowin", 64'(bus.now_allowin_o), 64'd1);
    chk("rst_count",   64'(bus.count_o), 64'd0);
    rst = 1'b0;

    // 2 fill with ID stalled, then drain
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h1c00_0000 + 32'(4*i), 7'h00);
      tick();
    end
    drive(1'b1, 32'h1c00_0020, 7'h00);   // 9th offered entry
    #1;
    chk("full_count",   64'(bus.count_o), 64'd8);
    chk("full_allowin", 64'(bus.now_allowin_o), 64'd0);
    chk("full_head",    64'(bus.id_pc_o), 64'h1c00_0000);
    tick();
    chk("full_9th_rejected", 64'(bus.count_o), 64'd8);
    drive(1'b0, 32'h0, 7'h00);
    bus.id_allowin_i = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 64'(bus.id_valid_o), 64'd1);
      chk("drain_pc",    64'(bus.id_pc_o), 64'(32'h1c00_0000 + 32'(4*i)));
      chk("drain_inst",  64'(bus.id_inst_o), 64'((32'h1c00_0000 + 32'(4*i)) ^ 32'h1357));
      tick();
    end
    chk("drained_valid", 64'(bus.id_valid_o), 64'd0);
    chk("drained_count", 64'(bus.count_o), 64'd0);

    // 3 steady push+pop at count=3 across the pointer wrap
    bus.id_allowin_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h1c00_0200 + 32'(4*k), 7'h00);
      tick();
    end
    bus.id_allowin_i = 1'b1;
    for (int j = 0; j < 10; j++) begin
      drive(1'b1, 32'h1c00_0200 + 32'(4*(j+3)), 7'h00);
      #1;
      chk("pp_count", 64'(bus.count_o), 64'd3);
      chk("pp_head",  64'(bus.id_pc_o), 64'(32'h1c00_0200 + 32'(4*j)));
      tick();
    end
    chk("pp_count_end", 64'(bus.count_o), 64'd3);
    drive(1'b0, 32'h0, 7'h00);
    for (int j = 10; j < 13; j++) begin
      #1;
      chk("pp_tail_pc", 64'(bus.id_pc_o), 64'(32'h1c00_0200 + 32'(4*j)));
      tick();
    end
    chk("pp_empty", 64'(bus.id_valid_o), 64'd0);

    // 4 flush with a concurrent push: other_flush_i, then excep_flush_i
    for (int f = 0; f < 2; f++) begin
      bus.id_allowin_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
        drive(1'b1, 32'h1c00_0300 + 32'(4*k), 7'h00);
        tick();
      end
      chk("fl_pre_count", 64'(bus.count_o), 64'd5);
      drive(1'b1, 32'h1c00_0100, 7'h00);
      if (f == 0) bus.other_flush_i = 1'b1;
      else        bus.excep_flush_i = 1'b1;
      tick();
      bus.other_flush_i = 1'b0;
      bus.excep_flush_i = 1'b0;
      drive(1'b0, 32'h0, 7'h00);
      bus.id_allowin_i = 1'b1;
      #1;
      chk("fl_count", 64'(bus.count_o), 64'd0);
      chk("fl_valid", 64'(bus.id_valid_o), 64'd0);
      tick();
      chk("fl_dropped", 64'(bus.id_valid_o), 64'd0);
    end

    // 5 exception entry kept in order
    bus.id_allowin_i = 1'b0;
    drive(1'b1, 32'h1c00_0000, 7'h00);                 tick();
    drive(1'b1, 32'h1c00_0003, {1'b1, ECODE_ADEF});    tick();
    drive(1'b1, 32'h1c00_0008, 7'h00);                 tick();
    drive(1'b0, 32'h0, 7'h00);
    bus.id_allowin_i = 1'b1;
    #1;
    chk("ex0_pc",   64'(bus.id_pc_o), 64'h1c00_0000);
    chk("ex0_excp", 64'(bus.id_excp_o), 64'h00);
    tick();
    chk("ex1_pc",   64'(bus.id_pc_o), 64'h1c00_0003);
    chk("ex1_excp", 64'(bus.id_excp_o), 64'h48);
    tick();
    chk("ex2_pc",   64'(bus.id_pc_o), 64'h1c00_0008);
    chk("ex2_excp", 64'(bus.id_excp_o), 64'h00);
    tick();
    chk("ex_empty", 64'(bus.id_valid_o), 64'd0);

    // count=1 with push and pop together stays at 1
    bus.id_allowin_i = 1'b0;
    drive(1'b1, 32'h1c00_0500, 7'h00); tick();
    bus.id_allowin_i = 1'b1;
    drive(1'b1, 32'h1c00_0504, 7'h00); tick();
    drive(1'b0, 32'h0, 7'h00);
    #1;
    chk("c1_count", 64'(bus.count_o), 64'd1);
    chk("c1_head",  64'(bus.id_pc_o), 64'h1c00_0504);
    tick();
    chk("c1_empty", 64'(bus.count_o), 64'd0);

    // 6 empty-queue latency
    drive(1'b1, 32'h1c00_0040, 7'h00);
    bus.id_allowin_i = 1'b1;
    #1;
`ifdef IBUF_BYPASS_EN
    chk("byp_valid", 64'(bus.id_valid_o), 64'd1);
    chk("byp_pc",    64'(bus.id_pc_o), 64'h1c00_0040);
    tick();
    drive(1'b0, 32'h0, 7'h00);
    #1;
    chk("byp_count", 64'(bus.count_o), 64'd0);
    chk("byp_after", 64'(bus.id_valid_o), 64'd0);
`else
    chk("lat_same_cycle", 64'(bus.id_valid_o), 64'd0);
    tick();
    drive(1'b0, 32'h0, 7'h00);
    #1;
    chk("lat_valid", 64'(bus.id_valid_o), 64'd1);
    chk("lat_pc",    64'(bus.id_pc_o), 64'h1c00_0040);
    tick();
    chk("lat_after", 64'(bus.id_valid_o), 64'd0);
`endif

    // reset mid-stream
    bus.id_allowin_i = 1'b0;
    drive(1'b1, 32'h1c00_0600, 7'h00); tick();
    drive(1'b1, 32'h1c00_0604, 7'h00); tick();
    chk("mr_pre_count", 64'(bus.count_o), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 7'h00);
    #1;
    chk("mr_count",   64'(bus.count_o), 64'd0);
    chk("mr_valid",   64'(bus.id_valid_o), 64'd0);
    chk("mr_allowin", 64'(bus.now_allowin_o), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
